// File: rtl/io_pkg.sv
// io_pkg: constants shared between the I/O initiator and the memory-mapped
// responder it drives.
//   BUS_RD / BUS_WR / BUS_IDLE : encodings of the responder write_select input
//   MEM_DEPTH_DEF              : default responder depth in words
//   state_t + ST_*             : initiator FSM state encoding
package io_pkg;

  localparam logic [1:0] BUS_RD   = 2'b00;
  localparam logic [1:0] BUS_WR   = 2'b01;
  localparam logic [1:0] BUS_IDLE = 2'b10;

  localparam int MEM_DEPTH_DEF = 256;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_WR_BEAT  = 3'd1;
  localparam state_t ST_RD_ISSUE = 3'd2;
  localparam state_t ST_RD_WAIT  = 3'd3;
  localparam state_t ST_RD_HOLD  = 3'd4;
  localparam state_t ST_DONE     = 3'd5;

endpackage

// File: rtl/io_initiator.sv
// io_initiator: burst bus master for the memory-mapped I/O responder.
// Ports:
//   clk, reset                    single clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/len burst command (beats = cmd_len+1)
//   wr_valid/ready/data           write beat stream in
//   rd_valid/ready/data           read beat stream out
//   done, err                     one-cycle pulses: burst complete / command rejected
//   busy                          FSM not in IDLE
//   bus_address/wdata/write_select  responder inputs (registered)
//   bus_rdata, bus_status         responder outputs
//   last_status                   bus_status captured on the latest read beat
module io_initiator
  import io_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF,
  parameter int READ_WAIT = 1,
  parameter int LEN_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic [ADDR_W-1:0] bus_address,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [1:0]        bus_write_select,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic [7:0]        bus_status,
  output logic [7:0]        last_status
);

  localparam int WCNT_W = $clog2(READ_WAIT + 1);
  localparam logic [ADDR_W:0]   DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(READ_WAIT);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;        // address of the next write beat
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          sel_q, sel_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [7:0]          status_q, status_d;
  logic                rd_valid_q, rd_valid_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [LEN_W-1:0]    beats_q, beats_d;    // beats remaining after the current one
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;      // cycles the current read has been on the bus

  // Last word address of the requested burst, one bit wider than the bus so
  // a command near the top of the address space cannot wrap into range.
  logic [ADDR_W:0]     cmd_end;
  logic                cmd_bad;

  assign cmd_end = {1'b0, cmd_addr} + {{(ADDR_W + 1 - LEN_W){1'b0}}, cmd_len};
  assign cmd_bad = (cmd_end >= DEPTH_LIM);

  assign cmd_ready = (state_q == ST_IDLE);
  assign wr_ready  = (state_q == ST_WR_BEAT);
  assign busy      = (state_q != ST_IDLE);

  assign bus_address      = bus_addr_q;
  assign bus_wdata        = wdata_q;
  assign bus_write_select = sel_q;
  assign rd_data          = rd_data_q;
  assign rd_valid         = rd_valid_q;
  assign last_status      = status_q;
  assign done             = done_q;
  assign err              = err_q;

  always_comb begin
    state_d    = state_q;
    bus_addr_d = bus_addr_q;
    ptr_d      = ptr_q;
    wdata_d    = wdata_q;
    sel_d      = sel_q;
    rd_data_d  = rd_data_q;
    status_d   = status_q;
    rd_valid_d = rd_valid_q;
    beats_d    = beats_q;
    wcnt_d     = wcnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sel_d = BUS_IDLE;
        if (cmd_valid) begin
          if (cmd_bad) begin
            // Rejected commands never touch the bus.
            err_d = 1'b1;
          end else begin
            bus_addr_d = cmd_addr;
            ptr_d      = cmd_addr;
            beats_d    = cmd_len;
            if (cmd_write) begin
              state_d = ST_WR_BEAT;
            end else begin
              // First read goes on the bus the very next cycle.
              state_d = ST_RD_ISSUE;
              sel_d   = BUS_RD;
              wcnt_d  = WCNT_W'(1);
            end
          end
        end
      end

      ST_WR_BEAT: begin
        sel_d = BUS_IDLE;
        if (wr_valid) begin
          // The accepted beat is presented for exactly the next cycle; the
          // pointer runs ahead so back-to-back beats need no bubble.
          sel_d      = BUS_WR;
          bus_addr_d = ptr_q;
          wdata_d    = wr_data;
          ptr_d      = ptr_q + ADDR_W'(1);
          if (beats_q == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            beats_d = beats_q - LEN_W'(1);
          end
        end
      end

      ST_RD_ISSUE, ST_RD_WAIT: begin
        sel_d = BUS_RD;
        if (wcnt_q == WAIT_LAST) begin
          // Responder output has settled for READ_WAIT cycles: capture it.
          rd_data_d  = bus_rdata;
          status_d   = bus_status;
          rd_valid_d = 1'b1;
          sel_d      = BUS_IDLE;
          state_d    = ST_RD_HOLD;
        end else begin
          wcnt_d  = wcnt_q + WCNT_W'(1);
          state_d = ST_RD_WAIT;
        end
      end

      ST_RD_HOLD: begin
        sel_d = BUS_IDLE;
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          bus_addr_d = bus_addr_q + ADDR_W'(1);
          if (beats_q == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            beats_d = beats_q - LEN_W'(1);
            sel_d   = BUS_RD;
            wcnt_d  = WCNT_W'(1);
            state_d = ST_RD_ISSUE;
          end
        end
      end

      ST_DONE: begin
        sel_d   = BUS_IDLE;
        state_d = ST_IDLE;
      end

      default: begin
        sel_d   = BUS_IDLE;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bus_addr_q <= '0;
      ptr_q      <= '0;
      wdata_q    <= '0;
      sel_q      <= BUS_IDLE;
      rd_data_q  <= '0;
      status_q   <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      beats_q    <= '0;
      wcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      bus_addr_q <= bus_addr_d;
      ptr_q      <= ptr_d;
      wdata_q    <= wdata_d;
      sel_q      <= sel_d;
      rd_data_q  <= rd_data_d;
      status_q   <= status_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
      beats_q    <= beats_d;
      wcnt_q     <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_io_initiator.sv
// Bench for io_initiator: a behavioural responder, a command table replayed
// through one task, and write/read scoreboards checked by a bus monitor.
module tb_io_initiator;
  import io_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int RW     = 1;
  localparam int LEN_W  = 4;
  localparam int AW_M   = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid, rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              done, err, busy;
  logic [ADDR_W-1:0] bus_address;
  logic [DATA_W-1:0] bus_wdata;
  logic [1:0]        bus_write_select;
  logic [DATA_W-1:0] bus_rdata;
  logic [7:0]        bus_status;
  logic [7:0]        last_status;

  always #5 clk = ~clk;

  io_initiator #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(DEPTH),
                 .READ_WAIT(RW), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err), .busy(busy),
    .bus_address(bus_address), .bus_wdata(bus_wdata),
    .bus_write_select(bus_write_select),
    .bus_rdata(bus_rdata), .bus_status(bus_status), .last_status(last_status)
  );

  // Responder: word memory, status is a fixed function of the address.
  logic [DATA_W-1:0] mem [DEPTH];
  assign bus_rdata  = mem[bus_address[AW_M-1:0]];
  assign bus_status = bus_address[7:0] ^ 8'hC3;
  always @(posedge clk)
    if (bus_write_select == BUS_WR) mem[bus_address[AW_M-1:0]] <= bus_wdata;

  typedef struct { logic [31:0] a; logic [31:0] d; } wr_exp_t;
  typedef struct { logic [31:0] d; logic [7:0] s; } rd_exp_t;
  typedef struct {
    bit wr; logic [31:0] addr; logic [3:0] len; logic [31:0] wbase;
    bit exp_err; int stall_beat; int stall_cyc;
  } vec_t;

  wr_exp_t     wr_q[$];
  rd_exp_t     rd_q[$];
  logic [31:0] ref_mem [DEPTH];
  vec_t        vecs [13];

  int checks = 0, errors = 0;
  int cyc = 0, bus_cyc = 0, done_cnt = 0, err_cnt = 0;
  int first_wr_cyc = -1, last_wr_cyc = -1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Bus / stream monitor, sampled mid-cycle.
  wr_exp_t we;
  rd_exp_t re;
  always @(negedge clk) begin
    if (bus_write_select === BUS_WR) begin
      bus_cyc++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      chk("wr_expected", 64'(wr_q.size() != 0), 64'd1);
      if (wr_q.size() != 0) begin
        we = wr_q.pop_front();
        chk("wr_addr", 64'(bus_address), 64'(we.a));
        chk("wr_data", 64'(bus_wdata), 64'(we.d));
      end
    end else if (bus_write_select === BUS_RD) begin
      bus_cyc++;
    end
    if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
      chk("rd_expected", 64'(rd_q.size() != 0), 64'd1);
      if (rd_q.size() != 0) begin
        re = rd_q.pop_front();
        chk("rd_data", 64'(rd_data), 64'(re.d));
        chk("last_status", 64'(last_status), 64'(re.s));
      end
    end
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 60) begin @(posedge clk); #1; t++; end
    repeat (2) @(posedge clk);
    #1;
    chk("done_once", 64'(done_cnt - d0), 64'd1);
    chk("idle_after", 64'(busy), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int t, d0, e0, b0, hs_prev;
    bit got;
    logic [31:0] a, d;
    t = 0;
    while (!cmd_ready && t < 60) begin @(posedge clk); #1; t++; end
    chk("cmd_ready", 64'(cmd_ready), 64'd1);
    d0 = done_cnt; e0 = err_cnt; b0 = bus_cyc; hs_prev = 0;
    cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_len = v.len;
    if (v.wr) begin wr_valid = 1'b1; wr_data = v.wbase; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (v.exp_err) begin
      chk("rej_wr_ready", 64'(wr_ready), 64'd0);
      chk("rej_busy", 64'(busy), 64'd0);
      chk("rej_err_now", 64'(err), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      wr_valid = 1'b0;
      chk("rej_err_once", 64'(err_cnt - e0), 64'd1);
      chk("rej_no_done", 64'(done_cnt - d0), 64'd0);
      chk("rej_no_bus", 64'(bus_cyc - b0), 64'd0);
    end else if (v.wr) begin
      first_wr_cyc = -1;
      for (int i = 0; i <= int'(v.len); i++) begin
        a = v.addr + 32'(i); d = v.wbase + 32'(i);
        wr_data = d; wr_valid = 1'b1;
        wr_q.push_back('{a, d});
        ref_mem[a[AW_M-1:0]] = d;
        got = 1'b0; t = 0;
        while (!got && t < 60) begin got = wr_ready; @(posedge clk); #1; t++; end
        chk("wr_handshake", 64'(got), 64'd1);
      end
      wr_valid = 1'b0;
      wait_done(d0);
      chk("wr_back_to_back", 64'(last_wr_cyc - first_wr_cyc), 64'(v.len));
      for (int i = 0; i <= int'(v.len); i++) begin
        a = v.addr + 32'(i);
        chk("mem_word", 64'(mem[a[AW_M-1:0]]), 64'(ref_mem[a[AW_M-1:0]]));
      end
    end else begin
      rd_ready = 1'b1;
      for (int i = 0; i <= int'(v.len); i++) begin
        a = v.addr + 32'(i);
        rd_q.push_back('{ref_mem[a[AW_M-1:0]], a[7:0] ^ 8'hC3});
        t = 0;
        while (!rd_valid && t < 60) begin @(posedge clk); #1; t++; end
        chk("rd_valid_seen", 64'(rd_valid), 64'd1);
        if (i == 0) chk("rd_first_latency", 64'(t), 64'(RW));
        if (i == v.stall_beat) begin
          rd_ready = 1'b0; b0 = bus_cyc;
          repeat (v.stall_cyc) begin
            @(posedge clk); #1;
            chk("stall_valid", 64'(rd_valid), 64'd1);
            chk("stall_data", 64'(rd_data), 64'(ref_mem[a[AW_M-1:0]]));
            chk("stall_bus_idle", 64'(bus_write_select), 64'(BUS_IDLE));
          end
          chk("stall_no_reads", 64'(bus_cyc - b0), 64'd0);
          rd_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("rd_valid_drop", 64'(rd_valid), 64'd0);
        if (i > 0 && i != v.stall_beat)
          chk("rd_beat_period", 64'(cyc - hs_prev), 64'(RW + 1));
        hs_prev = cyc;
      end
      wait_done(d0);
      rd_ready = 1'b0;
    end
  endtask

  int d0, e0, t;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

    //        wr    addr           len   wbase        err   stall  cyc
    vecs[0]  = '{1'b1, 32'h10,       4'd3,  32'hA0,   1'b0, -1, 0};
    vecs[1]  = '{1'b0, 32'h10,       4'd3,  32'h0,    1'b0, -1, 0};
    vecs[2]  = '{1'b0, 32'h10,       4'd3,  32'h0,    1'b0,  1, 5};
    vecs[3]  = '{1'b1, 32'hFD,       4'd3,  32'h55,   1'b1, -1, 0};
    vecs[4]  = '{1'b0, 32'hFD,       4'd3,  32'h0,    1'b1, -1, 0};
    vecs[5]  = '{1'b1, 32'hFC,       4'd3,  32'hB0,   1'b0, -1, 0};
    vecs[6]  = '{1'b0, 32'hFC,       4'd3,  32'h0,    1'b0, -1, 0};
    vecs[7]  = '{1'b1, 32'hFF,       4'd0,  32'hC0,   1'b0, -1, 0};
    vecs[8]  = '{1'b0, 32'h100,      4'd0,  32'h0,    1'b1, -1, 0};
    vecs[9]  = '{1'b1, 32'hFFFFFFFF, 4'd1,  32'h66,   1'b1, -1, 0};
    vecs[10] = '{1'b0, 32'hFF,       4'd0,  32'h0,    1'b0, -1, 0};
    vecs[11] = '{1'b1, 32'h20,       4'd15, 32'hD000, 1'b0, -1, 0};
    vecs[12] = '{1'b0, 32'h20,       4'd15, 32'h0,    1'b0,  7, 3};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_sel", 64'(bus_write_select), 64'(BUS_IDLE));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr", 64'(bus_address), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_status", 64'(last_status), 64'd0);
    @(posedge clk); #1;

    for (int v = 0; v < 13; v++) run_vec(vecs[v]);

    // Reset during beat 2 of a 16-beat write: beat 1 lands, nothing after.
    d0 = done_cnt; e0 = err_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_len = 4'd15;
    wr_valid = 1'b1; wr_data = 32'h1000;
    wr_q.push_back('{32'h10, 32'h1000});
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    wr_data = 32'h1001; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("wrst_busy", 64'(busy), 64'd0);
    chk("wrst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("wrst_sel", 64'(bus_write_select), 64'(BUS_IDLE));
    repeat (5) @(posedge clk);
    #1;
    wr_valid = 1'b0;
    chk("wrst_no_done", 64'(done_cnt - d0), 64'd0);
    chk("wrst_no_err", 64'(err_cnt - e0), 64'd0);
    chk("wrst_beat1", 64'(mem[8'h10]), 64'h1000);
    chk("wrst_beat2_kept", 64'(mem[8'h11]), 64'hA1);

    // Reset while a read beat is held: rd_valid must clear.
    d0 = done_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; cmd_len = 4'd15;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    t = 0;
    while (!rd_valid && t < 60) begin @(posedge clk); #1; t++; end
    chk("rrst_valid_seen", 64'(rd_valid), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rrst_rd_valid", 64'(rd_valid), 64'd0);
    chk("rrst_sel", 64'(bus_write_select), 64'(BUS_IDLE));
    chk("rrst_busy", 64'(busy), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("rrst_no_done", 64'(done_cnt - d0), 64'd0);

    chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
